id_ex_stage: RTL
================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register between the register file read and the execute stage.
//  - Captures decoded fields plus rs1/rs2 read data, with a write-back bypass for
//    same-cycle WB writes that the register file does not yet show.
//  - Detects load-use hazards, inserts bubbles, and handles flush and downstream hold.
//  - Keeps saturating bubble and flush counters.
// PARAMETERS
//  CTRL_W  8   width of opaque EX/MEM/WB control bundle passed through
//  CNT_W   16  width of saturating performance counters
// PORTS
//  clk            in   1      clock; all state updates on rising edge
//  rst            in   1      reset, asynchronous, active-low
//  id_valid       in   1      decode slot holds a real instruction
//  id_pc          in   32     PC of decode instruction
//  id_rs1,id_rs2  in   5      source register addresses
//  id_use_rs1/2   in   1      instruction actually reads rs1 / rs2
//  id_rd          in   5      destination register
//  id_rs1_data    in   32     register file read data for rs1
//  id_rs2_data    in   32     register file read data for rs2
//  id_imm         in   32     sign-extended immediate
//  id_reg_write   in   1      writes rd
//  id_mem_read    in   1      is a load
//  id_ctrl        in   CTRL_W remaining control bits
//  wb_we          in   1      WB write enable (same as register file writeEnable)
//  wb_rd          in   5      WB destination
//  wb_data        in   32     WB write data
//  flush          in   1      branch/jump redirect from EX: kill ID and EX contents
//  ex_hold        in   1      downstream cannot accept: freeze ID/EX
//  stall_id       out  1      combinational: IF/ID must hold
//  ex_valid       out  1      registered valid
//  ex_pc, ex_rs1, ex_rs2, ex_rd, ex_rs1_data, ex_rs2_data, ex_imm,
//  ex_reg_write, ex_mem_read, ex_ctrl
//                 out  -      registered copies of the id_* fields, same widths
//  bubble_cnt     out  CNT_W  load-use bubbles inserted, saturating
//  flush_cnt      out  CNT_W  flush cycles with ex_valid or id_valid set, saturating
// BEHAVIOUR
//  Reset: when rst=0, all registered outputs and counters are 0 immediately,
//  regardless of clk. This holds mid-operation.
//  Operand select, per source s:
//  - s==0: data is 0.
//  - else if wb_we & wb_rd==s: data is wb_data.
//  - else: data is id_rsN_data.
//  Load-use hazard (lu) is asserted when all of the following hold:
//  - id_valid, ex_valid, ex_mem_read, ex_rd!=0;
//  - (id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd).
//  stall_id = ~flush & (ex_hold | lu).
//  Per-edge update, in priority order:
//  1. flush: ex_valid<=0, other fields don't-care (zeroed); flush_cnt++ if
//     id_valid|ex_valid. Flush wins over hold and lu.
//  2. ex_hold: all ex_* fields keep their values, except the operand data.
//     If wb_we & wb_rd!=0 & wb_rd==ex_rsN, ex_rsN_data<=wb_data. This keeps
//     held operands current.
//  3. lu: bubble. ex_valid<=0, ex_reg_write<=0, ex_mem_read<=0, ex_ctrl<=0.
//     bubble_cnt++. The ID instruction re-presents next cycle.
//  4. else: capture all id_* fields with bypassed operand data.
//     ex_valid<=id_valid. When id_valid=0, ex_reg_write and ex_mem_read are 0.
//  Latency: one cycle from ID to EX; lu adds exactly one bubble cycle.
//  Counters stop at 2^CNT_W-1 and do not wrap.
//  A WB write to x0 is never bypassed.
// TESTING
//  1. rst low mid-run with ex_valid=1 -> all outputs 0 before the next edge;
//     release -> first capture is normal.
//  2. id_rs1=5, id_rs1_data=0x11, wb_we=1, wb_rd=5, wb_data=0xABCD -> next cycle
//     ex_rs1_data=0xABCD. Same case with wb_rd=0 and id_rs1=0 -> ex_rs1_data=0.
//  3. EX has a load, ex_rd=7; ID has add with rs2=7, use_rs2=1 -> stall_id=1,
//     ex_valid=0 for one cycle, bubble_cnt=1. Next cycle the add captures and
//     stall_id=0.
//  4. flush=1 together with lu=1 and ex_hold=1 -> stall_id=0, ex_valid=0,
//     flush_cnt incremented, bubble_cnt unchanged.
//  5. ex_hold=1 for 3 cycles with ex_rs2=9 and WB writes x9=0x55 in cycle 2 ->
//     ex_pc is unchanged, ex_rs2_data=0x55 after cycle 2, stall_id=1 throughout.
//  6. CNT_W=2: 5 load-use events -> bubble_cnt stays at 3.

Source files
------------

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with WB bypass, load-use bubbles, flush/hold and perf counters
module id_ex_stage #(
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [31:0]       id_pc,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [4:0]        id_rd,
  input  logic [31:0]       id_rs1_data,
  input  logic [31:0]       id_rs2_data,
  input  logic [31:0]       id_imm,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              wb_we,
  input  logic [4:0]        wb_rd,
  input  logic [31:0]       wb_data,
  input  logic              flush,
  input  logic              ex_hold,
  output logic              stall_id,
  output logic              ex_valid,
  output logic [31:0]       ex_pc,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [31:0]       ex_rs1_data,
  output logic [31:0]       ex_rs2_data,
  output logic [31:0]       ex_imm,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic [31:0] rs1_fwd;
  logic [31:0] rs2_fwd;
  logic        lu;
  logic        hold_fwd1;
  logic        hold_fwd2;

  // x0 reads as zero; a same-cycle WB write beats the stale register file value
  always_comb begin
    rs1_fwd = id_rs1_data;
    rs2_fwd = id_rs2_data;
    if (id_rs1 == 5'd0)
      rs1_fwd = '0;
    else if (wb_we && (wb_rd == id_rs1))
      rs1_fwd = wb_data;
    if (id_rs2 == 5'd0)
      rs2_fwd = '0;
    else if (wb_we && (wb_rd == id_rs2))
      rs2_fwd = wb_data;
  end

  always_comb begin
    lu = id_valid && ex_valid && ex_mem_read && (ex_rd != 5'd0) &&
         ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
    hold_fwd1 = wb_we && (wb_rd != 5'd0) && (wb_rd == ex_rs1);
    hold_fwd2 = wb_we && (wb_rd != 5'd0) && (wb_rd == ex_rs2);
  end

  assign stall_id = ~flush & (ex_hold | lu);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      ex_rd        <= '0;
      ex_rs1_data  <= '0;
      ex_rs2_data  <= '0;
      ex_imm       <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_ctrl      <= '0;
      bubble_cnt   <= '0;
      flush_cnt    <= '0;
    end else if (flush) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      ex_rd        <= '0;
      ex_rs1_data  <= '0;
      ex_rs2_data  <= '0;
      ex_imm       <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_ctrl      <= '0;
      if ((id_valid || ex_valid) && (flush_cnt != {CNT_W{1'b1}}))
        flush_cnt <= flush_cnt + 1'b1;
    end else if (ex_hold) begin
      // frozen instruction still tracks WB so it executes with current operands
      if (hold_fwd1)
        ex_rs1_data <= wb_data;
      if (hold_fwd2)
        ex_rs2_data <= wb_data;
    end else if (lu) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_ctrl      <= '0;
      if (bubble_cnt != {CNT_W{1'b1}})
        bubble_cnt <= bubble_cnt + 1'b1;
    end else begin
      ex_valid     <= id_valid;
      ex_pc        <= id_pc;
      ex_rs1       <= id_rs1;
      ex_rs2       <= id_rs2;
      ex_rd        <= id_rd;
      ex_rs1_data  <= rs1_fwd;
      ex_rs2_data  <= rs2_fwd;
      ex_imm       <= id_imm;
      ex_reg_write <= id_valid & id_reg_write;
      ex_mem_read  <= id_valid & id_mem_read;
      ex_ctrl      <= id_ctrl;
    end
  end

endmodule
